minbd_eject_stage: RTL
======================

Name: minbd_eject_stage

Overview:
- Pipeline stage of the MinBD deflection router that ejects at most one locally-destined flit per cycle from the four incoming channels.
- Eligible flits are arbitrated with a randomized rotating priority. The start index comes from an internal LFSR.
- The winner is moved into a registered ejection slot with a valid/ready handshake. All other flits pass to the next stage one cycle later, and locally-destined losers are deflected onward.

Parameters:
- FLIT_W, 64, flit width in bits; destination field is flit[DST_W-1:0]
- DST_W, 4, destination/router-id width
- SEED, 16'hACE1, LFSR reset value; if 0 is given, 16'hACE1 is used
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- local_id  in  DST_W  this router's id, quasi-static
- vld_in  in  4  per-channel flit valid
- flit_in  in  4*FLIT_W  channel i at [i*FLIT_W +: FLIT_W]
- rand_force_en  in  1  test hook: use rand_force instead of LFSR bits
- rand_force  in  2  forced start index
- vld_out  out  4  registered pass-through valid
- flit_out  out  4*FLIT_W  registered pass-through flits
- eject_vld  out  1  ejection slot holds a flit
- eject_rdy  in  1  local sink accepts the slot this cycle
- eject_flit  out  FLIT_W  ejected flit
- eject_chan  out  2  channel index the ejected flit arrived on
- eject_cnt  out  CNT_W  saturating count of ejections
- miss_cnt  out  CNT_W  saturating count of local flits deflected

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - vld_out=0, flit_out=0, eject_vld=0, eject_flit=0, eject_chan=0, eject_cnt=0, miss_cnt=0, lfsr=SEED.
  - Reset applies even mid-transfer; a held eject flit is dropped.
- Eligibility: elig[i] = vld_in[i] & (flit_in[i][DST_W-1:0] == local_id).
- Slot free: free = ~eject_vld | eject_rdy. A draining slot may be refilled in the same cycle.
- Start index: r = rand_force_en ? rand_force : lfsr[1:0].
- Grant:
  - If free, grant is one-hot on the first set elig index scanning r, r+1, r+2, r+3 (mod 4), with wrap-around.
  - If not free, or elig=0, grant=0.
- Pass-through, 1-cycle latency and no backpressure:
  - vld_out[i] <= vld_in[i] & ~grant[i].
  - flit_out[i] <= flit_in[i], loaded unconditionally.
- Eject register:
  - If grant≠0: eject_flit <= winning flit, eject_chan <= index, eject_vld <= 1.
  - Else if eject_rdy: eject_vld <= 0.
  - Else hold all eject outputs.
- Handshake:
  - Transfer occurs when eject_vld & eject_rdy.
  - eject_flit and eject_chan are stable while eject_vld=1 and eject_rdy=0.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shift left with feedback into bit 0.
  - Advances every non-reset cycle, including when rand_force_en=1.
- Counters:
  - eject_cnt += 1 when grant≠0.
  - miss_cnt += popcount(elig & ~grant), range 0..4.
  - Both saturate at all-ones and never wrap.
- Boundary cases:
  - Eligible flits with the slot full: all are deflected and counted as misses.
  - vld_in=0: the stage still registers flit_out data, with all valids 0.
  - A non-local flit is never granted.

Decomposition:
- Shared package minbd_pkg:
  - Constants NUM_CH=4, DEFAULT_SEED, LFSR tap mask.
  - Typedef chan_idx_t (2 bits).
  - Function for the destination-field slice.
- Sub-module minbd_rand_lfsr:
  - Ports clk, rst_n, lfsr_q.
  - Parameter SEED.
  - Outputs the 16-bit state; reusable by other MinBD stages.

Test Plan:
- Reset then idle: after rst_n deasserts, vld_out=0, eject_vld=0, counters=0 and stay 0 for 10 cycles with vld_in=0.
- Single eject: local_id=3, rand_force_en=1, rand_force=0, vld_in=4'b0100, flit_in[2] dst=3, eject_rdy=1.
  - Next cycle: eject_vld=1, eject_chan=2, vld_out=0000, eject_cnt=1.
- Wrap-around priority: elig on channels 0 and 1, rand_force=2.
  - Grant is channel 0; vld_out=0010, miss_cnt=1.
  - Repeat with rand_force=1: grant is channel 1.
- Backpressure: hold eject_rdy=0 after one eject, then present two local flits.
  - Slot unchanged; both flits appear on vld_out; miss_cnt increases by 2.
  - Raise eject_rdy with a new local flit present: the slot refills the same cycle and eject_vld stays 1.
- Non-local passthrough: vld_in=1111, all dst≠local_id.
  - vld_out=1111 and flit_out equals flit_in one cycle later; no grant.
- Saturation and LFSR:
  - Preload traffic for 2^CNT_W+5 ejections; eject_cnt stops at all-ones.
  - With SEED=16'hACE1, the first LFSR states match the golden model for 32 cycles.

Source files
------------

// File: rtl/minbd_pkg.sv
// rtl/minbd_pkg.sv - shared constants, types and helpers for MinBD router stages
// Contents:
//   NUM_CH        number of router channels
//   DEFAULT_SEED  LFSR seed used when a zero seed is requested
//   LFSR_TAPS     tap mask for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10)
//   chan_idx_t    channel index type
//   dst_field()   destination field of a flit (low dst_w bits, zero-extended to 16)
package minbd_pkg;

    localparam int          NUM_CH       = 4;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef logic [1:0] chan_idx_t;

    // Takes the low 16 bits of a flit and keeps only the destination field.
    function automatic logic [15:0] dst_field(input logic [15:0] flit_lo,
                                              input int unsigned dst_w);
        return flit_lo & 16'((17'd1 << dst_w) - 17'd1);
    endfunction

endpackage

// File: rtl/minbd_rand_lfsr.sv
// rtl/minbd_rand_lfsr.sv - 16-bit Fibonacci LFSR used for randomized arbitration
// Ports:
//   clk     in   clock
//   rst_n   in   synchronous active-low reset, loads the seed
//   lfsr_q  out  current 16-bit LFSR state, advances every non-reset cycle
module minbd_rand_lfsr
    import minbd_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr_q
);

    // An all-zero state would lock the LFSR, so a zero seed falls back.
    localparam logic [15:0] RESET_VAL = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/minbd_eject_stage.sv
// rtl/minbd_eject_stage.sv - MinBD ejection stage: ejects at most one local flit per cycle
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   local_id               this router's id
//   vld_in, flit_in        four incoming channels (channel i at [i*FLIT_W +: FLIT_W])
//   rand_force_en/force    override for the arbitration start index
//   vld_out, flit_out      registered pass-through channels (grant winner removed)
//   eject_vld/rdy          ejection slot handshake
//   eject_flit, eject_chan ejected flit and the channel it arrived on
//   eject_cnt, miss_cnt    saturating counts of ejections and deflected local flits
module minbd_eject_stage
    import minbd_pkg::*;
#(
    parameter int          FLIT_W = 64,
    parameter int          DST_W  = 4,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DST_W-1:0]      local_id,
    input  logic [3:0]            vld_in,
    input  logic [4*FLIT_W-1:0]   flit_in,
    input  logic                  rand_force_en,
    input  logic [1:0]            rand_force,
    output logic [3:0]            vld_out,
    output logic [4*FLIT_W-1:0]   flit_out,
    output logic                  eject_vld,
    input  logic                  eject_rdy,
    output logic [FLIT_W-1:0]     eject_flit,
    output logic [1:0]            eject_chan,
    output logic [CNT_W-1:0]      eject_cnt,
    output logic [CNT_W-1:0]      miss_cnt
);

    logic [15:0]         lfsr_q;
    logic [NUM_CH-1:0]   elig;
    logic [NUM_CH-1:0]   grant;
    logic [NUM_CH-1:0]   miss;
    logic [2:0]          miss_inc;
    logic [CNT_W:0]      miss_sum;
    logic                free;
    logic                found;
    chan_idx_t           start_idx;
    chan_idx_t           scan_idx;
    chan_idx_t           win_idx;
    logic [FLIT_W-1:0]   win_flit;

    minbd_rand_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_q (lfsr_q)
    );

    // A draining slot counts as free so it can be refilled back-to-back.
    assign free      = ~eject_vld | eject_rdy;
    assign start_idx = rand_force_en ? rand_force : lfsr_q[1:0];

    always_comb begin
        elig     = '0;
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        win_idx  = '0;
        win_flit = '0;
        miss_inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = vld_in[i] &
                      (dst_field(flit_in[i*FLIT_W +: 16], DST_W) == 16'(local_id));
        end
        // Rotating scan from the random start index, wrapping modulo 4.
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = start_idx + chan_idx_t'(k);
            if (free && !found && elig[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                win_idx         = scan_idx;
                found           = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                win_flit = flit_in[i*FLIT_W +: FLIT_W];
            end
        end
        miss = elig & ~grant;
        for (int i = 0; i < NUM_CH; i++) begin
            miss_inc = miss_inc + {2'b00, miss[i]};
        end
        miss_sum = {1'b0, miss_cnt} + (CNT_W+1)'(miss_inc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_out    <= '0;
            flit_out   <= '0;
            eject_vld  <= 1'b0;
            eject_flit <= '0;
            eject_chan <= '0;
            eject_cnt  <= '0;
            miss_cnt   <= '0;
        end else begin
            vld_out  <= vld_in & ~grant;
            flit_out <= flit_in;

            if (found) begin
                eject_flit <= win_flit;
                eject_chan <= win_idx;
                eject_vld  <= 1'b1;
            end else if (eject_rdy) begin
                eject_vld  <= 1'b0;
            end

            if (found && (eject_cnt != {CNT_W{1'b1}})) begin
                eject_cnt <= eject_cnt + CNT_W'(1);
            end

            // Carry out of the widened sum means the counter would wrap.
            if (miss_sum[CNT_W]) begin
                miss_cnt <= {CNT_W{1'b1}};
            end else begin
                miss_cnt <= miss_sum[CNT_W-1:0];
            end
        end
    end

endmodule
